// File: rtl/keypad_senha.sv
// keypad_senha: PIN-lock controller fed by the keypad decoder's 5-bit key code.
// Debounces presses, accumulates a BCD PIN, checks it on '#', and times the unlock, error and lockout states.
// Optional macro KEYPAD_SENHA_PROGRAM_EN: pressing 'A' while unlocked enters PROGRAM to store a new PIN.
module keypad_senha #(
  parameter int                   DIGITS        = 4,
  parameter logic [DIGITS*4-1:0]  DEFAULT_PWD   = 16'h1234,
  parameter int                   STABLE_CYCLES = 500000,
  parameter int                   OPEN_CYCLES   = 150000000,
  parameter int                   ERR_CYCLES    = 50000000,
  parameter int                   MAX_FAILS     = 3,
  parameter int                   LOCK_CYCLES   = 500000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          key,
  output logic [DIGITS*4-1:0] entry,
  output logic [3:0]          digit_count,
  output logic                unlocked,
  output logic                error,
  output logic                locked_out,
  output logic                press
);

  localparam int         EW     = DIGITS * 4;
  localparam logic [4:0] T_ASTE = 5'd14;
  localparam logic [4:0] T_HASH = 5'd15;
  localparam logic [4:0] T_NULL = 5'd16;
`ifdef KEYPAD_SENHA_PROGRAM_EN
  localparam logic [4:0] T_A    = 5'd10;
`endif
  localparam logic [7:0] FAIL_LAST = 8'(MAX_FAILS - 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_ERROR,
`ifdef KEYPAD_SENHA_PROGRAM_EN
    S_PROGRAM,
`endif
    S_LOCKOUT
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      key_n, key_prev, code;
  logic [31:0]     stab_cnt;
  logic            armed, stable;
  logic [31:0]     timer;
  logic            timer_done;
  logic [7:0]      fail_cnt;
  logic [EW-1:0]   pwd;
  logic            is_digit, full, match, accepting;

  // Out-of-range codes 17..31 look exactly like "no key".
  assign key_n      = (key > T_NULL) ? T_NULL : key;
  assign stable     = (stab_cnt == 32'(STABLE_CYCLES));
  assign is_digit   = (code <= 5'd9);
  assign full       = (digit_count == 4'(DIGITS));
  assign match      = full && (entry == pwd);
  assign timer_done = (timer == 32'd0);

`ifdef KEYPAD_SENHA_PROGRAM_EN
  assign accepting = (state == S_ENTRY) || (state == S_PROGRAM);
`else
  assign accepting = (state == S_ENTRY);
  assign pwd       = DEFAULT_PWD;
`endif

  // Debouncer: one press per stable non-null code, rearmed only by a stable release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev <= T_NULL;
      stab_cnt <= 32'd0;
      armed    <= 1'b0;
      press    <= 1'b0;
      code     <= T_NULL;
    end else begin
      key_prev <= key_n;
      press    <= 1'b0;
      if (key_n != key_prev)
        stab_cnt <= 32'd0;
      else if (!stable)
        stab_cnt <= stab_cnt + 32'd1;
      if (armed && stable && key_prev != T_NULL) begin
        press <= 1'b1;
        code  <= key_prev;
        armed <= 1'b0;
      end else if (!armed && stable && key_prev == T_NULL) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ENTRY;
    else     state <= state_nxt;
  end

  // FSM next-state logic; key events come from the registered press pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ENTRY: begin
        if (press && code == T_HASH) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (match)                      state_nxt = S_OPEN;
        else if (fail_cnt >= FAIL_LAST) state_nxt = S_LOCKOUT;
        else                            state_nxt = S_ERROR;
      end
      S_OPEN: begin
        if (press && code == T_ASTE) state_nxt = S_ENTRY;
`ifdef KEYPAD_SENHA_PROGRAM_EN
        else if (press && code == T_A) state_nxt = S_PROGRAM;
`endif
        else if (timer_done) state_nxt = S_ENTRY;
      end
      S_ERROR, S_LOCKOUT: begin
        if (timer_done) state_nxt = S_ENTRY;
      end
`ifdef KEYPAD_SENHA_PROGRAM_EN
      S_PROGRAM: begin
        if (press && code == T_HASH) state_nxt = full ? S_ENTRY : S_ERROR;
      end
`endif
      default: state_nxt = S_ENTRY;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    unlocked   = 1'b0;
    error      = 1'b0;
    locked_out = 1'b0;
    case (state)
      S_OPEN:    unlocked   = 1'b1;
`ifdef KEYPAD_SENHA_PROGRAM_EN
      S_PROGRAM: unlocked   = 1'b1;
`endif
      S_ERROR:   error      = 1'b1;
      S_LOCKOUT: locked_out = 1'b1;
      default:   unlocked   = 1'b0;
    endcase
  end

  // Digit accumulator: shift in BCD digits, clear on '*' and whenever a PIN has been consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry       <= '0;
      digit_count <= 4'd0;
    end else if (state == S_CHECK) begin
      entry       <= '0;
      digit_count <= 4'd0;
    end else if (accepting && press) begin
      if (is_digit && !full) begin
        entry       <= EW'({entry, code[3:0]});
        digit_count <= digit_count + 4'd1;
      end else if (code == T_ASTE) begin
        entry       <= '0;
        digit_count <= 4'd0;
      end
`ifdef KEYPAD_SENHA_PROGRAM_EN
      else if (state == S_PROGRAM && code == T_HASH) begin
        entry       <= '0;
        digit_count <= 4'd0;
      end
`endif
    end
  end

  // Consecutive-failure counter: cleared by a good PIN or by serving a lockout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fail_cnt <= 8'd0;
    else if (state == S_CHECK)
      fail_cnt <= match ? 8'd0 : fail_cnt + 8'd1;
    else if (state == S_LOCKOUT && state_nxt == S_ENTRY)
      fail_cnt <= 8'd0;
  end

  // State timer: loaded with N-1 on entry so the timed state lasts exactly N cycles; frozen in PROGRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= 32'd0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        S_OPEN:    timer <= 32'(OPEN_CYCLES - 1);
        S_ERROR:   timer <= 32'(ERR_CYCLES - 1);
        S_LOCKOUT: timer <= 32'(LOCK_CYCLES - 1);
        default:   timer <= timer;
      endcase
    end else if ((state == S_OPEN || state == S_ERROR || state == S_LOCKOUT) && !timer_done) begin
      timer <= timer - 32'd1;
    end
  end

`ifdef KEYPAD_SENHA_PROGRAM_EN
  // Stored PIN: replaced only by a complete entry confirmed with '#' in PROGRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pwd <= DEFAULT_PWD;
    else if (state == S_PROGRAM && press && code == T_HASH && full)
      pwd <= entry;
  end
`endif

endmodule
